// File: rtl/nx_axbs_pkg.sv
// Shared scheduler state encoding and result-width helper for the nx_axbs slice scheduler.
package nx_axbs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Full linear convolution of NUM_A by NUM_B operands yields this many coefficients.
   function automatic int calc_nout(input int num_a, input int num_b);
      return num_a + num_b - 1;
   endfunction

endpackage

// File: rtl/nx_axbs_res_fifo.sv
// Result buffer for the slice scheduler: power-of-two circular FIFO with occupancy count and clear.
module nx_axbs_res_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign push_ok = push && (count_q != CW'(DEPTH));
   assign pop_ok  = pop && !empty;

   // Pointers are AW bits wide over a power-of-two depth, so the increment wraps on its own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clr) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/nx_axbs_sched.sv
// Issue scheduler for a fixed-latency slice array with a credit-limited result FIFO.
// Optional NX_AXBS_SCHED_STATS_EN adds saturating job / stall counters.
module nx_axbs_sched
   import nx_axbs_pkg::*;
#(
   parameter int NUM_A      = 2,
   parameter int NUM_B      = 2,
   parameter int SIZE_OUT   = 16,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int NOUT = calc_nout(NUM_A, NUM_B),
   localparam int RW   = NOUT * SIZE_OUT,
   localparam int CW   = $clog2(FIFO_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUM_A*8-1:0] in_a,
   input  logic [NUM_B*8-1:0] in_b,
   input  logic               flush,
   output logic [NUM_A*8-1:0] dp_a,
   output logic [NUM_B*8-1:0] dp_b,
   output logic               dp_issue,
   input  logic [RW-1:0]      dp_res,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RW-1:0]      out_res,
   output logic               busy
`ifdef NX_AXBS_SCHED_STATS_EN
   ,
   output logic [31:0]        stat_jobs,
   output logic [31:0]        stat_stall
`endif
);

   state_t             state_q, state_d;
   logic [CW-1:0]      inflight_q, inflight_d;
   logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
   logic               dp_issue_q, dp_issue_d;
   logic [NUM_A*8-1:0] dp_a_q, dp_a_d;
   logic [NUM_B*8-1:0] dp_b_q, dp_b_d;

   logic [CW-1:0]      fifo_count;
   logic               fifo_empty, fifo_push, fifo_pop, fifo_clr;
   logic [RW-1:0]      fifo_dout;
   logic [CW:0]        credit_used;
   logic               accept, res_arrive;

   // Credits come from registered counts only, so a pop frees its slot one cycle later.
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign in_ready    = !rst && (state_q != ST_DRAIN) && !flush
                        && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign accept      = in_valid && in_ready;
   assign res_arrive  = vld_sr_q[LATENCY-1];

   assign fifo_push = res_arrive && (state_q != ST_DRAIN);
   assign fifo_clr  = (state_q == ST_DRAIN);
   assign out_valid = !fifo_empty && (state_q != ST_DRAIN);
   assign fifo_pop  = out_valid && out_ready;
   assign out_res   = out_valid ? fifo_dout : '0;
   assign busy      = (state_q != ST_IDLE);

   assign dp_issue = dp_issue_q;
   assign dp_a     = dp_a_q;
   assign dp_b     = dp_b_q;

   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      dp_issue_d = accept;
      dp_a_d     = accept ? in_a : dp_a_q;
      dp_b_d     = accept ? in_b : dp_b_q;
      vld_sr_d   = (vld_sr_q << 1) | LATENCY'(dp_issue_q);

      if (accept && !res_arrive)      inflight_d = inflight_q + CW'(1);
      else if (!accept && res_arrive) inflight_d = inflight_q - CW'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (flush)         state_d = ST_DRAIN;
            else if (in_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (flush) state_d = ST_DRAIN;
            else if (inflight_q == '0 && fifo_empty && !in_valid) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (inflight_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inflight_q <= '0;
         vld_sr_q   <= '0;
         dp_issue_q <= 1'b0;
         dp_a_q     <= '0;
         dp_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         vld_sr_q   <= vld_sr_d;
         dp_issue_q <= dp_issue_d;
         dp_a_q     <= dp_a_d;
         dp_b_q     <= dp_b_d;
      end
   end

   nx_axbs_res_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (fifo_clr),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (dp_res),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty)
   );

`ifdef NX_AXBS_SCHED_STATS_EN
   logic [31:0] stat_jobs_q, stat_jobs_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Counters survive flush; only reset clears them.
   always_comb begin
      stat_jobs_d  = accept ? sat_inc(stat_jobs_q) : stat_jobs_q;
      stat_stall_d = (in_valid && !in_ready) ? sat_inc(stat_stall_q) : stat_stall_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_jobs_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_jobs_q  <= stat_jobs_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_jobs  = stat_jobs_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_nx_axbs_sched.sv
// Scoreboard bench for nx_axbs_sched with a behavioural fixed-latency convolution slice array.
module tb_nx_axbs_sched;

   localparam int NA  = 2;
   localparam int NB  = 2;
   localparam int SO  = 16;
   localparam int LAT = 4;
   localparam int FD  = 4;
   localparam int NO  = NA + NB - 1;
   localparam int RW  = NO * SO;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NA*8-1:0] in_a = '0;
   logic [NB*8-1:0] in_b = '0;
   logic          flush = 1'b0;
   logic [NA*8-1:0] dp_a;
   logic [NB*8-1:0] dp_b;
   logic          dp_issue;
   logic [RW-1:0] dp_res;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [RW-1:0] out_res;
   logic          busy;
`ifdef NX_AXBS_SCHED_STATS_EN
   logic [31:0]   stat_jobs;
   logic [31:0]   stat_stall;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cnt = 0;
   logic [RW-1:0] exp_q[$];
   int            acc_t[$];
   logic [RW-1:0] pipe [LAT];

   nx_axbs_sched #(
      .NUM_A(NA), .NUM_B(NB), .SIZE_OUT(SO), .LATENCY(LAT), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .flush(flush), .dp_a(dp_a), .dp_b(dp_b),
      .dp_issue(dp_issue), .dp_res(dp_res), .out_valid(out_valid),
      .out_ready(out_ready), .out_res(out_res), .busy(busy)
`ifdef NX_AXBS_SCHED_STATS_EN
      , .stat_jobs(stat_jobs), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] conv(input logic [NA*8-1:0] a, input logic [NB*8-1:0] b);
      logic [RW-1:0]        r;
      logic signed [SO-1:0] s;
      logic signed [7:0]    x, y;
      r = '0;
      for (int k = 0; k < NO; k++) begin
         s = '0;
         for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
               if (i + j == k) begin
                  x = a[i*8 +: 8];
                  y = b[j*8 +: 8];
                  s = s + (SO'(x) * SO'(y));
               end
            end
         end
         r[k*SO +: SO] = s;
      end
      return r;
   endfunction

   // Slice array model: result of the operands issued in cycle c is on dp_res in cycle c+LAT.
   always @(posedge clk) begin
      pipe[0] <= conv(dp_a, dp_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign dp_res = pipe[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(conv(in_a, in_b));
            acc_t.push_back(cyc);
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", 64'(out_valid), 64'd0);
            else chk("out_res", 64'(out_res), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cycle();
      logic took;
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) begin
         in_a = 16'($urandom);
         in_b = 16'($urandom);
      end
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < lim) begin
         step();
         n++;
      end
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_dp_issue"}, 64'(dp_issue), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_dp_a"}, 64'(dp_a), 64'd0);
      chk({tag, "_dp_b"}, 64'(dp_b), 64'd0);
      chk({tag, "_out_res"}, 64'(out_res), 64'd0);
   endtask

   initial begin
      int base, n, maxw, w;
      #2;
      check_all_zero("rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // Single job a={1,2}, b={3,4} -> {3,10,8}
      in_a = 16'h0201; in_b = 16'h0403; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_issue", 64'(dp_issue), 64'd1);
      chk("t1_dp_a", 64'(dp_a), 64'h0201);
      chk("t1_dp_b", 64'(dp_b), 64'h0403);
      step();
      chk("t2_issue", 64'(dp_issue), 64'd0);
      for (int k = 2; k <= 5; k++) begin
         chk("t_early_ov", 64'(out_valid), 64'd0);
         step();
      end
      chk("t6_ov", 64'(out_valid), 64'd1);
      chk("t6_res", 64'(out_res), 64'h0008_000A_0003);
      chk("t6_busy", 64'(busy), 64'd1);
      out_ready = 1'b1;
      step();
      wait_idle("single", 20);

      // Backpressure: six offers, four credits
      out_ready = 1'b0;
      base = acc_cnt;
      for (int j = 0; j < 6; j++) begin
         logic got;
         in_a = 16'($urandom); in_b = 16'($urandom); in_valid = 1'b1;
         n = 0;
         got = 1'b0;
         while (!got && n < 4) begin
            @(negedge clk);
            got = in_ready;
            step();
            n++;
         end
      end
      in_valid = 1'b0;
      chk("bp_accepted", 64'(acc_cnt - base), 64'd4);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      wait_idle("bp_drain", 40);

      // Streaming with out_ready held high
      acc_t.delete();
      in_a = 16'($urandom); in_b = 16'($urandom); in_valid = 1'b1;
      for (int i = 0; i < 40; i++) drive_cycle();
      in_valid = 1'b0;
      maxw = 0;
      for (int i = 0; i < acc_t.size(); i++) begin
         w = 0;
         for (int j = 0; j < acc_t.size(); j++)
            if (acc_t[j] >= acc_t[i] && acc_t[j] < acc_t[i] + 7) w++;
         if (w > maxw) maxw = w;
      end
      chk("stream_win7", 64'(maxw), 64'd4);
      chk("stream_rate", 64'(acc_t.size() >= 20), 64'd1);
      wait_idle("stream_drain", 40);

      // Flush with three jobs in flight
      out_ready = 1'b0;
      base = acc_cnt;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_a = 16'($urandom); in_b = 16'($urandom);
         step();
      end
      in_valid = 1'b0;
      flush = 1'b1;
      #1;
      chk("fl_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      chk("fl_accepted", 64'(acc_cnt - base), 64'd3);
      chk("fl_busy", 64'(busy), 64'd1);
      exp_q.delete();
      n = 0;
      while (busy && n < LAT + 4) begin
         chk("fl_out_valid", 64'(out_valid), 64'd0);
         step();
         n++;
      end
      chk("fl_idle", 64'(busy), 64'd0);
      out_ready = 1'b1;
      repeat (6) begin
         chk("fl_empty_ov", 64'(out_valid), 64'd0);
         step();
      end

      // First result after flush must be the new job: a={5,-1}, b={-2,2} -> {-10,12,-2}
      out_ready = 1'b0;
      in_a = 16'hFF05; in_b = 16'h02FE; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 12) begin
         step();
         n++;
      end
      chk("pf_res", 64'(out_res), 64'hFFFE_000C_FFF6);
      out_ready = 1'b1;
      wait_idle("pf_drain", 20);

      // Reset with two jobs in flight
      in_valid = 1'b1;
      repeat (2) begin
         in_a = 16'($urandom); in_b = 16'($urandom);
         step();
      end
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check_all_zero("mr");
      exp_q.delete();
      step();
      step();
      rst = 1'b0;
      repeat (12) begin
         chk("mr_no_out", 64'(out_valid), 64'd0);
         step();
      end
      chk("mr_busy", 64'(busy), 64'd0);

`ifdef NX_AXBS_SCHED_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("st_jobs_rst", 64'(stat_jobs), 64'd0);
      chk("st_stall_rst", 64'(stat_stall), 64'd0);
      out_ready = 1'b0;
      in_a = 16'h0102; in_b = 16'h0304; in_valid = 1'b1;
      repeat (7) step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle("st_drain", 30);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_idle("st_last", 20);
      chk("st_jobs", 64'(stat_jobs), 64'd5);
      chk("st_stall", 64'(stat_stall), 64'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nx_axbs_sched.md
NX_AXBS_SCHED -- requirements
Module: nx_axbs_sched

Interface
REQ-001 SHALL have parameter NUM_A, default 2: number of int8 A operands per job.
REQ-002 SHALL have parameter NUM_B, default 2: number of int8 B operands per job.
REQ-003 SHALL have parameter SIZE_OUT, default 16: width of each result coefficient.
REQ-004 SHALL have parameter LATENCY, default 4: fixed issue-to-result latency of the external slice array.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two, at least 2.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid / in_ready, input / output, 1 each: job handshake.
REQ-009 SHALL have port in_a / in_b, input, NUM_A*8 / NUM_B*8: packed operands, element 0 in the LSBs.
REQ-010 SHALL have port flush, input, 1: request to drain and empty the block.
REQ-011 SHALL have port dp_a / dp_b, output, NUM_A*8 / NUM_B*8: operands to the slice array.
REQ-012 SHALL have port dp_issue, output, 1: the operands on dp_a/dp_b are valid this cycle.
REQ-013 SHALL have port dp_res, input, NOUT*SIZE_OUT, where NOUT = NUM_A+NUM_B-1: slice-array results, coefficient k in slot k.
REQ-014 SHALL have port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-015 SHALL have port out_res, output, NOUT*SIZE_OUT: buffered result, head of the FIFO.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, RUN and DRAIN, with RUN entered from IDLE on the first cycle in which in_valid=1 and flush=0.
REQ-018 SHALL set in_ready=1 only when state is IDLE or RUN, flush=0, and fifo_count+inflight < FIFO_DEPTH, with both counts taken from current-cycle registers.
REQ-019 SHALL accept a job when in_valid and in_ready are both high, register the operands onto dp_a/dp_b, and pulse dp_issue for exactly one cycle on the following cycle.
REQ-020 SHALL track in-flight jobs with a LATENCY-deep valid shift register, capturing dp_res into the FIFO exactly LATENCY cycles after the corresponding dp_issue.
REQ-021 SHALL drive out_valid=1 whenever the FIFO is non-empty and pop one entry when out_valid and out_ready are both high.
REQ-022 SHALL, on a same-cycle FIFO push and pop, leave fifo_count unchanged, and SHALL NOT return the credit freed by a pop before the next cycle.
REQ-023 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, and the credit rule SHALL guarantee that the FIFO never overflows.
REQ-024 SHALL move from RUN to IDLE when inflight=0, the FIFO is empty and in_valid=0.
REQ-025 SHALL move from IDLE or RUN to DRAIN on flush=1; in DRAIN, in_ready=0 and out_valid=0.
REQ-026 SHALL, in DRAIN, discard results that arrive and clear the FIFO, then return to IDLE once inflight reaches 0.
REQ-027 SHALL pass dp_res through unmodified, with no width conversion inside the block.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state=IDLE, both counts=0, the valid shift register=0, and both FIFO pointers=0.
REQ-029 SHALL hold all outputs at 0 during reset: in_ready, dp_issue, out_valid, busy, dp_a, dp_b and out_res.
REQ-030 SHALL discard all in-flight jobs on reset asserted mid-operation; no stale result SHALL appear after reset is released.

Configuration
REQ-031 SHALL, with NX_AXBS_SCHED_STATS_EN defined, add 32-bit output ports stat_jobs (accepted jobs) and stat_stall (cycles with in_valid=1 and in_ready=0), both reset to 0, saturating and not cleared by flush.
REQ-032 SHALL, without NX_AXBS_SCHED_STATS_EN, omit these ports and their counters entirely.

Structure
REQ-033 SHALL place the state enum (IDLE, RUN, DRAIN) and the NOUT computation function in the shared package nx_axbs_pkg.
REQ-034 SHALL implement the result buffer as the sub-module nx_axbs_res_fifo, which has synchronous push/pop, count output and asynchronous reset.

Verification
REQ-035 SHALL cover a single job: NUM_A=NUM_B=2, LATENCY=4, a={1,2}, b={3,4}, with a model slice array -> dp_issue at cycle t+1, FIFO push at t+5, out_res={3,10,8}.
REQ-036 SHALL cover backpressure: out_ready=0 with 6 jobs offered -> exactly 4 accepted, in_ready=0 thereafter, no overflow; raising out_ready drains the results in order.
REQ-037 SHALL cover steady-state streaming: out_ready=1 with FIFO_DEPTH=4 and LATENCY=4 -> no more than 4 jobs accepted within any LATENCY-cycle window, and results delivered in order.
REQ-038 SHALL cover flush: flush asserted with 3 jobs in flight -> out_valid=0, busy=1 for up to LATENCY cycles, then IDLE with an empty FIFO.
REQ-039 SHALL cover mid-stream reset: rst pulsed with 2 jobs in flight -> all outputs 0 immediately, and no result emitted afterwards.
REQ-040 SHALL cover the stats counters: with NX_AXBS_SCHED_STATS_EN defined, 5 jobs and 3 stall cycles -> stat_jobs=5, stat_stall=3.
